spi_cmd_regs: RTL and testbench
===============================

// Module: spi_cmd_regs
// PURPOSE
// - Downstream consumer of the SPI slave: takes each completed 32-bit SPI frame, decodes it as a register command,
//   updates a bank of control registers (PWM periods, LED/debug values) and builds the response word for the next frame.
// - Sits between the SPI slave (frame_word/frame_valid in, resp_word out) and the PWM/LED logic in the top level.
// PARAMETERS
// - NUM_REGS   8     number of control registers (addresses 0..NUM_REGS-1)
// - REG_W      16    register width; register bank data is frame bits [REG_W-1:0], REG_W <= 16
// - RESET_VAL  0     value of every register after reset
// PORTS
// - clk          in   1                  system clock (CLK_50 at top level)
// - reset        in   1                  synchronous, active-high reset
// - frame_word   in   32                 last received SPI frame; stable from frame_valid rise until next frame
// - frame_valid  in   1                  SPI data_ready, SPI-clock domain; asynchronous to clk
// - resp_word    out  32                 word the SPI slave shifts out on the next frame
// - resp_valid   out  1                  one-cycle pulse when resp_word has been updated
// - regs_flat    out  NUM_REGS*REG_W     register bank, reg[i] at [i*REG_W +: REG_W]
// - err_cnt      out  8                  count of rejected frames, saturating at 255
// - ovr_cnt      out  8                  count of frames dropped while busy, saturating at 255
// BEHAVIOUR
// - Frame format: [31:24] cmd, [23:16] addr, [15:0] data. cmd: 0x00 NOP, 0x01 WRITE, 0x02 READ, anything else is illegal.
// - frame_valid passes through a 2-flop synchronizer and then a rising-edge detector. On the edge, frame_word is captured into an internal latch.
// - FSM IDLE -> DECODE -> EXEC -> RESP -> IDLE, one cycle per state. The edge is accepted only in IDLE.
// - Latency: edge at sync output cycle N; resp_word/resp_valid update in cycle N+3.
// - DECODE: status = OK(0x00); cmd illegal -> ILL(0x01); WRITE/READ with addr >= NUM_REGS -> RANGE(0x02).
// - EXEC: WRITE with OK writes reg[addr] <= data[REG_W-1:0]. No write for any other case.
// - RESP: resp_word = {status, addr, zero-extended reg[addr]}. For READ/WRITE the register value is post-write.
//   For NOP, or when status != OK, the data field is 0x0000.
// - Non-OK status increments err_cnt (saturating).
// - Edge detected outside IDLE: frame dropped, ovr_cnt++ (saturating), FSM and capture latch untouched.
// - reset (any state, mid-op included): FSM -> IDLE, regs -> RESET_VAL, resp_word -> 0, resp_valid -> 0,
//   counters -> 0, synchronizer/edge flops -> 0. No spurious edge on the first cycle after reset.
// - Counters hold at 255; they never wrap.
// CONFIGURATION
// - CMD_PARITY_EN defined: frame bit 31 is an even-parity bit over bits[30:0] and cmd is the 7-bit field [30:24].
//   A parity mismatch gives status PAR(0x03), no write, and err_cnt++. Parity is checked before cmd/addr checks.
//   The response word's bit 31 is set so the response also has even parity.
// - CMD_PARITY_EN undefined: cmd is the full [31:24] field, no parity check, resp_word as defined above.
// STRUCTURE
// - Package spi_cmd_pkg:
//   - cmd localparams (CMD_NOP, CMD_WRITE, CMD_READ)
//   - status localparams (ST_OK, ST_ILL, ST_RANGE, ST_PAR)
//   - state enum typedef (IDLE, DECODE, EXEC, RESP)
//   - field bit-position constants
// - Sub-module sync_edge: 2-flop synchronizer plus rising-edge pulse, with clk and reset ports; reused for other async inputs.
// - Register bank, FSM and counters stay in spi_cmd_regs.
// TESTING
// - WRITE 0x01_03_01F4, then READ 0x02_03_0000:
//   - reg[3] = 0x01F4
//   - both resp_word = 0x00_03_01F4
//   - resp_valid pulses 3 cycles after each synced edge
// - cmd 0x7F, and WRITE to addr 0x08 (NUM_REGS=8): status 0x01 and 0x02 respectively, no register changes, err_cnt = 2.
// - Second frame_valid edge in DECODE or EXEC: ovr_cnt = 1, first command completes normally, second has no effect.
// - Assert reset during EXEC of WRITE 0x01_00_1234:
//   - reg[0] = 0
//   - resp_word = 0, resp_valid never pulses
//   - a new frame after reset is processed normally
// - 300 illegal frames: err_cnt = 255 (saturated).
// - With CMD_PARITY_EN:
//   - a frame with bad parity returns status 0x03 and causes no write
//   - a correctly-parity WRITE updates the register
//   - every resp_word has even parity

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared constants and types for the SPI register command decoder
//
// Purpose: command and status codes, FSM state type, frame field positions
// and small helper functions used by spi_cmd_regs.
// Ports: none (package).
// Build option: CMD_PARITY_EN (consumed by spi_cmd_regs, not by this package).

package spi_cmd_pkg;

  // Command codes (frame bits [31:24], or [30:24] when the parity bit is in use)
  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  // Response status codes (response bits [31:24])
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_ILL   = 8'h01;
  localparam logic [7:0] ST_RANGE = 8'h02;
  localparam logic [7:0] ST_PAR   = 8'h03;

  // Frame field positions
  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;
  localparam int PAR_BIT  = 31;

  // Both saturating counters stop here
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic logic cmd_legal(input logic [7:0] cmd);
    return (cmd == CMD_NOP) || (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

  function automatic logic cmd_uses_addr(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer followed by a rising-edge pulse generator
//
// Purpose: brings an asynchronous level into the clk domain and emits a
// single-cycle pulse for every rising edge seen at the synchronizer output.
// Ports:
//   clk      in  1  destination clock
//   reset    in  1  synchronous, active-high; clears all three flops
//   async_in in  1  asynchronous level input
//   level    out 1  synchronized level
//   rise     out 1  one-cycle pulse on a synchronized 0->1 transition

module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // sync and sync_d both clear together, so the first cycle after reset
  // cannot produce a pulse; a still-high input shows up as a genuine edge
  // only after it has walked through the synchronizer.
  assign level = sync;
  assign rise  = sync & ~sync_d;

endmodule

// File: rtl/spi_cmd_regs.sv
// rtl/spi_cmd_regs.sv - decodes completed SPI frames into register commands and builds the reply word
//
// Purpose: each rising edge of frame_valid (after synchronization) captures
// frame_word, runs it through IDLE -> DECODE -> EXEC -> RESP, updates the
// control register bank and publishes the response for the next SPI frame.
// Build option: CMD_PARITY_EN - frame bit 31 is an even-parity bit, cmd
// shrinks to [30:24], bad parity answers ST_PAR, and the response carries
// its own even-parity bit in bit 31.
// Ports:
//   clk          in  1                 system clock
//   reset        in  1                 synchronous, active-high
//   frame_word   in  32                last received SPI frame
//   frame_valid  in  1                 SPI data_ready, asynchronous to clk
//   resp_word    out 32                reply shifted out on the next frame
//   resp_valid   out 1                 one-cycle pulse when resp_word updates
//   regs_flat    out NUM_REGS*REG_W    register bank, reg[i] at [i*REG_W +: REG_W]
//   err_cnt      out 8                 rejected frames, saturating
//   ovr_cnt      out 8                 frames dropped while busy, saturating

module spi_cmd_regs
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 16,
  parameter int RESET_VAL = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               frame_word,
  input  logic                      frame_valid,
  output logic [31:0]               resp_word,
  output logic                      resp_valid,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic [7:0]                err_cnt,
  output logic [7:0]                ovr_cnt
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

  // ---------------------------------------------------------------------
  // frame_valid synchronization
  // ---------------------------------------------------------------------
  logic frame_level;
  logic frame_rise;

  sync_edge u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (frame_valid),
    .level    (frame_level),
    .rise     (frame_rise)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   accept;
  logic   drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_rise) begin
          accept     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Any edge arriving while a command is in flight is discarded; the
    // capture latch keeps the frame being processed.
    if (frame_rise && (state != IDLE)) begin
      drop = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Captured frame fields
  // ---------------------------------------------------------------------
  logic [31:0]      frame_q;
  logic [7:0]       cmd;
  logic [7:0]       addr;
  logic [REG_W-1:0] wr_data;
  logic [AW-1:0]    idx;
  logic             par_ok;
  logic             addr_ok;

`ifdef CMD_PARITY_EN
  assign cmd    = {1'b0, frame_q[CMD_MSB-1:CMD_LSB]};
  assign par_ok = ~(^frame_q);
`else
  assign cmd    = frame_q[CMD_MSB:CMD_LSB];
  assign par_ok = 1'b1;
`endif

  assign addr    = frame_q[ADDR_MSB:ADDR_LSB];
  assign wr_data = frame_q[DATA_LSB+REG_W-1:DATA_LSB];
  assign idx     = addr[AW-1:0];
  assign addr_ok = ({1'b0, addr} < NUM_REGS_L);

  // ---------------------------------------------------------------------
  // Status decode (parity first, then cmd, then address range)
  // ---------------------------------------------------------------------
  logic [7:0] status_next;
  logic [7:0] status_q;

  always_comb begin
    status_next = ST_OK;
    if (!par_ok) begin
      status_next = ST_PAR;
    end else if (!cmd_legal(cmd)) begin
      status_next = ST_ILL;
    end else if (cmd_uses_addr(cmd) && !addr_ok) begin
      status_next = ST_RANGE;
    end
  end

  // ---------------------------------------------------------------------
  // Register bank and response
  // ---------------------------------------------------------------------
  logic [REG_W-1:0] regs [NUM_REGS];
  logic             do_write;
  logic [15:0]      data_field;
  logic [31:0]      resp_base;
  logic [31:0]      resp_next;

  assign do_write = (state == EXEC) && (status_q == ST_OK) && (cmd == CMD_WRITE);

  // The response is built in EXEC, in parallel with the register write, so
  // a WRITE reports the incoming data (the post-write value) directly.
  always_comb begin
    data_field = 16'h0000;
    if (status_q == ST_OK) begin
      if (cmd == CMD_WRITE) begin
        data_field = 16'(wr_data);
      end else if (cmd == CMD_READ) begin
        data_field = 16'(regs[idx]);
      end
    end
    resp_base = {status_q, addr, data_field};
    resp_next = resp_base;
`ifdef CMD_PARITY_EN
    // Status codes never use bit 31, so it is free to carry the parity.
    resp_next[PAR_BIT] = ^resp_base[PAR_BIT-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q    <= '0;
      status_q   <= ST_OK;
      resp_word  <= '0;
      resp_valid <= 1'b0;
      err_cnt    <= '0;
      ovr_cnt    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= REG_W'(RESET_VAL);
      end
    end else begin
      resp_valid <= 1'b0;

      if (accept) begin
        frame_q <= frame_word;
      end

      if (drop && (ovr_cnt != CNT_MAX)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end

      if (state == DECODE) begin
        status_q <= status_next;
      end

      // Loading at the EXEC->RESP boundary makes resp_valid high during RESP.
      if (state == EXEC) begin
        resp_word  <= resp_next;
        resp_valid <= 1'b1;
        if ((status_q != ST_OK) && (err_cnt != CNT_MAX)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      if (do_write) begin
        regs[idx] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = regs[g];
  end

  // The synchronized level itself is not needed here; only its edge is.
  logic unused_level;
  assign unused_level = frame_level;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// tb/tb_spi_cmd_regs.sv - directed self-checking bench for spi_cmd_regs

module tb_spi_cmd_regs;

  logic         clk;
  logic         reset;
  logic [31:0]  frame_word;
  logic         frame_valid;
  logic [31:0]  resp_word;
  logic         resp_valid;
  logic [127:0] regs_flat;
  logic [7:0]   err_cnt;
  logic [7:0]   ovr_cnt;

  int checks;
  int failures;

  spi_cmd_regs #(.NUM_REGS(8), .REG_W(16), .RESET_VAL(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_word  (frame_word),
    .frame_valid (frame_valid),
    .resp_word   (resp_word),
    .resp_valid  (resp_valid),
    .regs_flat   (regs_flat),
    .err_cnt     (err_cnt),
    .ovr_cnt     (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame as it goes on the wire (bit 31 becomes parity when enabled)
  function automatic logic [31:0] mk(input logic [31:0] w);
`ifdef CMD_PARITY_EN
    return {^w[30:0], w[30:0]};
`else
    return w;
`endif
  endfunction

  // Expected response word for a given status/addr/data
  function automatic logic [31:0] er(input logic [7:0] st, input logic [7:0] a, input logic [15:0] d);
    logic [31:0] r;
    r = {st, a, d};
`ifdef CMD_PARITY_EN
    r[31] = ^r[30:0];
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_word  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one frame and watches 12 cycles; lat is the posedge index of the
  // first resp_valid pulse counted from the frame_valid rise (-1 if none).
  task automatic run_frame(input logic [31:0] w, output logic [31:0] resp,
                           output int lat, output int npulse);
    @(negedge clk);
    frame_word  = w;
    frame_valid = 1'b1;
    lat    = -1;
    npulse = 0;
    resp   = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) frame_valid = 1'b0;
      if (resp_valid) begin
        npulse++;
        if (lat < 0) begin
          lat  = i;
          resp = resp_word;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_word  = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_word !== 32'h0) begin failures++; $display("FAIL reset_resp_word got=%h exp=%h", resp_word, 32'h0); end
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (regs_flat !== 128'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", regs_flat); end
    checks++;
    if (err_cnt !== 8'h0 || ovr_cnt !== 8'h0) begin
      failures++; $display("FAIL reset_counters got err=%h ovr=%h exp=00/00", err_cnt, ovr_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_no_spurious cycle=%0d got=%b exp=0", i, resp_valid); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] r;
    int lat, np;
    do_reset();
    run_frame(mk(32'h0103_01F4), r, lat, np);
    checks++;
    if (r !== er(8'h00, 8'h03, 16'h01F4)) begin failures++; $display("FAIL write_resp got=%h exp=%h", r, er(8'h00, 8'h03, 16'h01F4)); end
    checks++;
    if (lat !== 5 || np !== 1) begin failures++; $display("FAIL write_latency got lat=%0d pulses=%0d exp lat=5 pulses=1", lat, np); end
    checks++;
    if (regs_flat !== (128'h01F4 << 48)) begin failures++; $display("FAIL write_regs got=%h exp=%h", regs_flat, 128'h01F4 << 48); end
    run_frame(mk(32'h0203_0000), r, lat, np);
    checks++;
    if (r !== er(8'h00, 8'h03, 16'h01F4)) begin failures++; $display("FAIL read_resp got=%h exp=%h", r, er(8'h00, 8'h03, 16'h01F4)); end
    checks++;
    if (lat !== 5 || np !== 1) begin failures++; $display("FAIL read_latency got lat=%0d pulses=%0d exp lat=5 pulses=1", lat, np); end
    run_frame(mk(32'h0003_5555), r, lat, np);
    checks++;
    if (r !== er(8'h00, 8'h03, 16'h0000)) begin failures++; $display("FAIL nop_resp got=%h exp=%h", r, er(8'h00, 8'h03, 16'h0000)); end
    run_frame(mk(32'h0107_ABCD), r, lat, np);
    checks++;
    if (regs_flat[7*16 +: 16] !== 16'hABCD || regs_flat[3*16 +: 16] !== 16'h01F4) begin
      failures++; $display("FAIL write_top_reg got=%h exp=%h", regs_flat, (128'hABCD << 112) | (128'h01F4 << 48));
    end
    checks++;
    if (err_cnt !== 8'd0) begin failures++; $display("FAIL ok_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    int lat, np;
    do_reset();
    run_frame(mk(32'h7F00_0000), r, lat, np);
    checks++;
    if (r !== er(8'h01, 8'h00, 16'h0000)) begin failures++; $display("FAIL illegal_resp got=%h exp=%h", r, er(8'h01, 8'h00, 16'h0000)); end
    run_frame(mk(32'h0108_ABCD), r, lat, np);
    checks++;
    if (r !== er(8'h02, 8'h08, 16'h0000)) begin failures++; $display("FAIL range_resp got=%h exp=%h", r, er(8'h02, 8'h08, 16'h0000)); end
    checks++;
    if (regs_flat !== 128'h0) begin failures++; $display("FAIL error_no_write got=%h exp=0", regs_flat); end
    checks++;
    if (err_cnt !== 8'd2) begin failures++; $display("FAIL err_cnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_back_to_back();
    int np;
    logic [31:0] r;
    do_reset();
    np = 0;
    r  = '0;
    @(negedge clk);
    frame_word  = mk(32'h0102_5A5A);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    @(negedge clk);
    frame_valid = 1'b1;          // second rise lands while the first is in EXEC
    @(negedge clk);
    frame_word  = mk(32'h0105_BEEF);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) frame_valid = 1'b0;
      if (resp_valid) begin
        np++;
        r = resp_word;
      end
    end
    checks++;
    if (ovr_cnt !== 8'd1) begin failures++; $display("FAIL ovr_cnt got=%0d exp=1", ovr_cnt); end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", np); end
    checks++;
    if (r !== er(8'h00, 8'h02, 16'h5A5A)) begin failures++; $display("FAIL overrun_first_resp got=%h exp=%h", r, er(8'h00, 8'h02, 16'h5A5A)); end
    checks++;
    if (regs_flat !== (128'h5A5A << 32)) begin failures++; $display("FAIL overrun_regs got=%h exp=%h", regs_flat, 128'h5A5A << 32); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat, np;
    do_reset();
    np = 0;
    @(negedge clk);
    frame_word  = mk(32'h0100_1234);
    frame_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) frame_valid = 1'b0;
      if (resp_valid) np++;
    end
    @(negedge clk);
    reset = 1'b1;                // sampled on the edge that would end EXEC
    @(posedge clk);
    #1;
    if (resp_valid) np++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) np++;
    end
    checks++;
    if (np !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", np); end
    checks++;
    if (regs_flat[15:0] !== 16'h0000) begin failures++; $display("FAIL midreset_reg0 got=%h exp=0000", regs_flat[15:0]); end
    checks++;
    if (resp_word !== 32'h0) begin failures++; $display("FAIL midreset_resp got=%h exp=0", resp_word); end
    run_frame(mk(32'h0100_1234), r, lat, np);
    checks++;
    if (r !== er(8'h00, 8'h00, 16'h1234) || lat !== 5) begin
      failures++; $display("FAIL after_reset_write got=%h lat=%0d exp=%h lat=5", r, lat, er(8'h00, 8'h00, 16'h1234));
    end
    checks++;
    if (regs_flat[15:0] !== 16'h1234) begin failures++; $display("FAIL after_reset_reg0 got=%h exp=1234", regs_flat[15:0]); end
  endtask

  task automatic test_saturation();
    logic [31:0] r;
    int lat, np;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      run_frame(mk(32'h7F00_0000), r, lat, np);
    end
    checks++;
    if (err_cnt !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", err_cnt); end
    checks++;
    if (ovr_cnt !== 8'd0) begin failures++; $display("FAIL sat_ovr got=%0d exp=0", ovr_cnt); end
  endtask

`ifdef CMD_PARITY_EN
  task automatic test_parity();
    logic [31:0] r;
    int lat, np;
    do_reset();
    run_frame(mk(32'h0104_1111) ^ 32'h8000_0000, r, lat, np);
    checks++;
    if (r !== er(8'h03, 8'h04, 16'h0000)) begin failures++; $display("FAIL parity_bad_resp got=%h exp=%h", r, er(8'h03, 8'h04, 16'h0000)); end
    checks++;
    if (regs_flat !== 128'h0 || err_cnt !== 8'd1) begin
      failures++; $display("FAIL parity_bad_effect got regs=%h err=%0d exp regs=0 err=1", regs_flat, err_cnt);
    end
    checks++;
    if (^r !== 1'b0) begin failures++; $display("FAIL parity_resp_even_1 got=%h exp=even", r); end
    run_frame(mk(32'h0104_2222), r, lat, np);
    checks++;
    if (regs_flat[4*16 +: 16] !== 16'h2222) begin failures++; $display("FAIL parity_good_write got=%h exp=2222", regs_flat[4*16 +: 16]); end
    checks++;
    if (r !== er(8'h00, 8'h04, 16'h2222) || ^r !== 1'b0) begin
      failures++; $display("FAIL parity_good_resp got=%h exp=%h", r, er(8'h00, 8'h04, 16'h2222));
    end
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_word  = '0;
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
`ifdef CMD_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
